// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit RISC-V DIV/DIVU/REM/REMU iterative divider
//
// Purpose: restoring shift-subtract divider, one quotient bit per cycle.
//   It runs through 32 CALC cycles and then one FIX cycle that applies the
//   sign correction and the RISC-V divide-by-zero and overflow results.
// Optional feature: define DIV_EARLY_OUT_EN so that divisor-zero and signed
//   overflow finish straight from IDLE (1-cycle latency).
//
// Ports:
//   CLK    in   1  clock, rising edge
//   RESET  in   1  synchronous active-high reset
//   START  in   1  request strobe, sampled only in IDLE
//   OP     in   2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1  in  32  dividend
//   DATA2  in  32  divisor
//   BUSY   out  1  high in CALC and FIX
//   DONE   out  1  one-cycle pulse, RESULT valid
//   RESULT out 32  registered quotient or remainder
module div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;        // {remainder, quotient}
  logic [31:0] div_q, div_d;      // divisor magnitude
  logic [1:0]  op_q, op_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;

  // Operand preparation at START
  logic        signed_op;
  logic        sign1, sign2;
  logic [31:0] abs1, abs2;
  logic        dz_in, ovf_in;

  assign signed_op = ~OP[0];
  assign sign1     = signed_op & DATA1[31];
  assign sign2     = signed_op & DATA2[31];
  assign abs1      = sign1 ? (32'd0 - DATA1) : DATA1;
  assign abs2      = sign2 ? (32'd0 - DATA2) : DATA2;
  assign dz_in     = (DATA2 == 32'd0);
  assign ovf_in    = signed_op & (DATA1 == 32'h8000_0000) & (DATA2 == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_OUT_EN
  logic [31:0] early_res;
  assign early_res = dz_in ? (OP[1] ? DATA1 : 32'hFFFF_FFFF)
                           : (OP[1] ? 32'd0 : 32'h8000_0000);
`endif

  // One restoring step. The shifted partial remainder is 33 bits wide
  // because the remainder can exceed 2^31 when the divisor is above 2^31.
  // When the subtraction succeeds the true difference is below the divisor,
  // so its low 32 bits are exact.
  logic        ge;
  logic [31:0] diff;
  logic [63:0] rq_step;

  assign ge      = (rq_q[63:31] >= {1'b0, div_q});
  assign diff    = rq_q[62:31] - div_q;
  assign rq_step = ge ? {diff, rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};

  // Sign correction and special-case overrides
  logic [31:0] quo_s, rem_s, fix_res;

  assign quo_s = neg_quo_q ? (32'd0 - rq_q[31:0])  : rq_q[31:0];
  assign rem_s = neg_rem_q ? (32'd0 - rq_q[63:32]) : rq_q[63:32];

  always_comb begin
    fix_res = op_q[1] ? rem_s : quo_s;
    if (dz_q) begin
      // rem_s restores the original dividend: |a| with the sign of a
      fix_res = op_q[1] ? rem_s : 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      fix_res = op_q[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      rq_q      <= 64'd0;
      div_q     <= 32'd0;
      op_q      <= 2'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rq_q      <= rq_d;
      div_q     <= div_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rq_d      = rq_q;
    div_d     = div_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    BUSY      = 1'b0;
    DONE      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d      = OP;
          div_d     = abs2;
          rq_d      = {32'd0, abs1};
          neg_quo_d = sign1 ^ sign2;
          neg_rem_d = sign1;
          dz_d      = dz_in;
          ovf_d     = ovf_in;
          cnt_d     = 5'd0;
          state_d   = S_CALC;
`ifdef DIV_EARLY_OUT_EN
          if (dz_in || ovf_in) begin
            result_d = early_res;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        BUSY  = 1'b1;
        rq_d  = rq_step;
        cnt_d = cnt_q + 5'd1;      // wraps 31 -> 0 on the last step
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        BUSY     = 1'b1;
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RESULT = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  div_unit dut (
    .CLK    (clk),
    .RESET  (reset),
    .START  (start),
    .OP     (op),
    .DATA1  (data1),
    .DATA2  (data2),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    bit special;
    special = (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (EARLY && special) ? 1 : 34;
  endfunction

  // Runs one operation. chain=1: START is already raised during the previous
  // DONE cycle. hold=1: return in the DONE cycle so the caller can chain.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb, input bit chain,
                        input bit hold);
    int cycles;
    logic [31:0] exp;
    int lat;
    exp = ref_div(o, a, b);
    lat = ref_lat(o, a, b);
    op = o; data1 = a; data2 = b; start = 1'b1;
    if (chain) begin
      @(posedge clk); #1;
      chk({tag, "_chain_idle_done"}, 32'(done), 32'd0);
      chk({tag, "_chain_idle_busy"}, 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    if (lat == 34) chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    while (!done && cycles < 100) begin
      if (disturb) begin
        data1 = $urandom; data2 = $urandom; op = 2'($urandom);
        start = (cycles == 3 || cycles == 20);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'(lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_result_hold"}, result, exp);
    end
  endtask

  initial begin
    int nodone;
    logic [31:0] a, b;
    logic [1:0] o;
    reset = 1'b1; start = 1'b0; op = 2'd0; data1 = 32'd0; data2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);

    // Reset wins over a simultaneous START
    start = 1'b1; data1 = 32'd50; data2 = 32'd5; op = 2'b01;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("reset_vs_start_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("reset_vs_start_idle", 32'(busy), 32'd0);

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 1'b0);
    run_op("div_5_0", 2'b00, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("rem_5_0", 2'b10, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 1'b0);

    // START ignored while busy, then back-to-back via START in DONE cycle
    run_op("divu_1000_3", 2'b01, 32'd1000, 32'd3, 1'b1, 1'b0, 1'b1);
    run_op("chain_rem", 2'b10, 32'hFFFF_FC18, 32'd7, 1'b0, 1'b1, 1'b0);

    // Reset in CALC cycle 10 discards the operation
    op = 2'b01; data1 = 32'd12345; data2 = 32'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    nodone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nodone++;
    end
    chk("midreset_no_done", 32'(nodone), 32'd0);
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);

    // Randomized operations with mixed operand classes
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = {28'hFFFF_FFF, 4'($urandom)};
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), o, a, b, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
